ipif_regs_v2: RTL and testbench

Parametrised IPIF-attached software register file; next generation of the team's simple WO/RW/RO register bank.
Adds per-byte write enables and explicit range/access-type error responses.
Adds per-register write strobes and clear-on-read pulses toward hardware, plus a handshake FSM that guarantees exactly one ack per bus access.
Sits between the AXI-Lite IPIF slave and a pcore's datapath/statistics logic.

---
 rtl/nf10_regs_pkg.sv | 12 +
 rtl/ipif_regs_v2_if.sv | 23 ++
 rtl/ipif_regs_decode.sv | 35 +++
 rtl/ipif_regs_v2.sv | 118 +++++++++++
 tb/tb_ipif_regs_v2.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/nf10_regs_pkg.sv
// nf10_regs_pkg: shared access-type and FSM encodings plus elaboration-time helpers
// for the IPIF register bank.
package nf10_regs_pkg;
    function automatic int log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    typedef enum logic [1:0] {ACC_WO, ACC_RW, ACC_RO, ACC_NONE} acc_t;
    typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_HOLD} state_t;
endpackage

// File: rtl/ipif_regs_v2_if.sv
// ipif_regs_v2_if: IPIF slave bus between the AXI-Lite IPIF (master) and a register bank (slave).
interface ipif_regs_v2_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   Bus2IP_Addr;
    logic                            Bus2IP_CS;
    logic                            Bus2IP_RNW;
    logic [C_S_AXI_DATA_WIDTH-1:0]   Bus2IP_Data;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] Bus2IP_BE;
    logic [C_S_AXI_DATA_WIDTH-1:0]   IP2Bus_Data;
    logic                            IP2Bus_RdAck;
    logic                            IP2Bus_WrAck;
    logic                            IP2Bus_Error;
    modport master (
        output Bus2IP_Addr, Bus2IP_CS, Bus2IP_RNW, Bus2IP_Data, Bus2IP_BE,
        input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
    );
    modport slave (
        input  Bus2IP_Addr, Bus2IP_CS, Bus2IP_RNW, Bus2IP_Data, Bus2IP_BE,
        output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
    );
endinterface

// File: rtl/ipif_regs_decode.sv
// ipif_regs_decode: maps a byte address to region, region-local index and access error.
module ipif_regs_decode
    import nf10_regs_pkg::*;
#(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int NUM_WO = 2,
    parameter int NUM_RW = 2,
    parameter int NUM_RO = 4,
    parameter int IW     = log2(NUM_WO + NUM_RW + NUM_RO)
) (
    input  logic [AW-1:0] addr,
    input  logic          rnw,
    output acc_t          acc,
    output logic [IW-1:0] idx,
    output logic          err
);
    localparam int NT   = NUM_WO + NUM_RW + NUM_RO;
    localparam int RO_B = NUM_WO + NUM_RW;
    localparam int LSB  = log2(DW / 8);
    localparam int MSB  = LSB + IW;
    localparam logic [IW:0]   NT_W    = NT[IW:0];
    localparam logic [IW-1:0] RW_BASE = NUM_WO[IW-1:0];
    localparam logic [IW-1:0] RO_BASE = RO_B[IW-1:0];
    logic [IW-1:0] word;
    logic          oor;
    assign word = addr[MSB-1:LSB];
    // indices past the last register are out of range even when no high address bit is set
    assign oor = (addr >> MSB) != '0 || {1'b0, word} >= NT_W;
    always_comb begin
        acc = oor ? ACC_NONE : word < RW_BASE ? ACC_WO : word < RO_BASE ? ACC_RW : ACC_RO;
        idx = acc == ACC_RW ? word - RW_BASE : acc == ACC_RO ? word - RO_BASE : word;
        err = rnw ? (acc == ACC_WO || acc == ACC_NONE) : (acc == ACC_RO || acc == ACC_NONE);
    end
endmodule

// File: rtl/ipif_regs_v2.sv
// ipif_regs_v2: IPIF software register bank with WO/RW/RO regions, byte enables,
// write strobes, clear-on-read pulses and a one-ack-per-access handshake.
module ipif_regs_v2
    import nf10_regs_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int NUM_WO_REGS = 2,
    parameter int NUM_RW_REGS = 2,
    parameter int NUM_RO_REGS = 4,
    parameter logic [NUM_RO_REGS-1:0] RO_COR_MASK = '0,
    parameter logic [NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0] RW_RESET_VAL = '0
) (
    input  logic                                      Bus2IP_Clk,
    input  logic                                      Bus2IP_Reset,
    ipif_regs_v2_if.slave                             bus,
    output logic [NUM_WO_REGS*C_S_AXI_DATA_WIDTH-1:0] wo_regs,
    output logic [NUM_WO_REGS-1:0]                    wo_wr_stb,
    output logic [NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0] rw_regs,
    output logic [NUM_RW_REGS-1:0]                    rw_wr_stb,
    input  logic [NUM_RO_REGS*C_S_AXI_DATA_WIDTH-1:0] ro_regs,
    output logic [NUM_RO_REGS-1:0]                    ro_rd_clr
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int IW = log2(NUM_WO_REGS + NUM_RW_REGS + NUM_RO_REGS);
    state_t                 state, state_nx;
    acc_t                   acc;
    logic [IW-1:0]          idx;
    logic                   err, access, wr, ack, rnw_q, err_q;
    logic [NUM_WO_REGS-1:0] wo_hit, wo_stb_q;
    logic [NUM_RW_REGS-1:0] rw_hit, rw_stb_q;
    logic [NUM_RO_REGS-1:0] ro_hit, clr_q;
    logic [DW-1:0]          bmask, rd_val, rd_data_q;

    ipif_regs_decode #(
        .AW(C_S_AXI_ADDR_WIDTH), .DW(DW), .NUM_WO(NUM_WO_REGS),
        .NUM_RW(NUM_RW_REGS), .NUM_RO(NUM_RO_REGS), .IW(IW)
    ) u_decode (
        .addr(bus.Bus2IP_Addr),
        .rnw (bus.Bus2IP_RNW),
        .acc (acc),
        .idx (idx),
        .err (err)
    );

    // the access is performed only on the IDLE cycle, so a CS held high cannot retrigger it
    assign access = state == ST_IDLE && bus.Bus2IP_CS;
    assign wr     = access && !bus.Bus2IP_RNW;

    always_comb begin
        wo_hit = '0;
        rw_hit = '0;
        ro_hit = '0;
        rd_val = '0;
        bmask  = '0;
        for (int i = 0; i < NUM_WO_REGS; i++) wo_hit[i] = acc == ACC_WO && idx == IW'(i);
        for (int i = 0; i < NUM_RW_REGS; i++) begin
            rw_hit[i] = acc == ACC_RW && idx == IW'(i);
            if (rw_hit[i]) rd_val = rw_regs[i*DW +: DW];
        end
        for (int i = 0; i < NUM_RO_REGS; i++) begin
            ro_hit[i] = acc == ACC_RO && idx == IW'(i);
            if (ro_hit[i]) rd_val = ro_regs[i*DW +: DW];
        end
        for (int b = 0; b < DW / 8; b++) bmask[b*8 +: 8] = {8{bus.Bus2IP_BE[b]}};
    end

    always_ff @(posedge Bus2IP_Clk)
        if (Bus2IP_Reset) begin
            wo_regs <= '0;
            rw_regs <= RW_RESET_VAL;
        end else begin
            for (int i = 0; i < NUM_WO_REGS; i++)
                if (wr && wo_hit[i])
                    wo_regs[i*DW +: DW] <= (wo_regs[i*DW +: DW] & ~bmask) | (bus.Bus2IP_Data & bmask);
            for (int i = 0; i < NUM_RW_REGS; i++)
                if (wr && rw_hit[i])
                    rw_regs[i*DW +: DW] <= (rw_regs[i*DW +: DW] & ~bmask) | (bus.Bus2IP_Data & bmask);
        end

    always_ff @(posedge Bus2IP_Clk)
        if (Bus2IP_Reset) begin
            rnw_q     <= 1'b0;
            err_q     <= 1'b0;
            wo_stb_q  <= '0;
            rw_stb_q  <= '0;
            clr_q     <= '0;
            rd_data_q <= '0;
        end else begin
            wo_stb_q <= wr ? wo_hit : '0;
            rw_stb_q <= wr ? rw_hit : '0;
            clr_q    <= access && bus.Bus2IP_RNW ? ro_hit & RO_COR_MASK : '0;
            if (access) begin
                rnw_q <= bus.Bus2IP_RNW;
                err_q <= err;
            end
            if (access && bus.Bus2IP_RNW) rd_data_q <= rd_val;
        end

    always_ff @(posedge Bus2IP_Clk) state <= Bus2IP_Reset ? ST_IDLE : state_nx;

    always_comb
        state_nx = state == ST_IDLE ? (bus.Bus2IP_CS ? ST_ACK : ST_IDLE) :
                   state == ST_ACK  ? ST_HOLD :
                   (bus.Bus2IP_CS ? ST_HOLD : ST_IDLE);

    always_comb begin
        ack              = state == ST_ACK;
        bus.IP2Bus_RdAck = ack && rnw_q;
        bus.IP2Bus_WrAck = ack && !rnw_q;
        bus.IP2Bus_Error = ack && err_q;
        wo_wr_stb        = ack ? wo_stb_q : '0;
        rw_wr_stb        = ack ? rw_stb_q : '0;
        ro_rd_clr        = ack ? clr_q : '0;
    end

    assign bus.IP2Bus_Data = rd_data_q;
endmodule

// File: tb/tb_ipif_regs_v2.sv
// tb_ipif_regs_v2: directed accesses push expected responses; a negedge monitor
// pops and compares them whenever the DUT acks.
module tb_ipif_regs_v2;
    typedef struct {
        logic        rnw;
        logic        err;
        logic [31:0] data;
        logic [1:0]  wo_stb;
        logic [1:0]  rw_stb;
        logic [3:0]  clr;
        logic [63:0] wo;
        logic [63:0] rw;
    } exp_t;

    localparam logic [63:0] RW_RST = {32'h0BAD_F00D, 32'hA5A5_A5A5};
    localparam logic [63:0] WOF    = 64'hDEAD_BEEF_1122_FF44;
    localparam logic [63:0] RW6    = 64'h0BAD_F00D_5566_A5A5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [63:0]  wo_regs, rw_regs;
    logic [1:0]   wo_wr_stb, rw_wr_stb;
    logic [3:0]   ro_rd_clr;
    logic [31:0]  ro0;
    logic [127:0] ro_regs;
    exp_t         q[$];
    exp_t         cur;
    int           total = 0, bad = 0, acks = 0, pushes = 0;

    ipif_regs_v2_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32)) bus ();

    ipif_regs_v2 #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32),
        .NUM_WO_REGS(2), .NUM_RW_REGS(2), .NUM_RO_REGS(4),
        .RO_COR_MASK(4'b0001), .RW_RESET_VAL(RW_RST)
    ) dut (
        .Bus2IP_Clk  (clk),
        .Bus2IP_Reset(rst),
        .bus         (bus),
        .wo_regs     (wo_regs),
        .wo_wr_stb   (wo_wr_stb),
        .rw_regs     (rw_regs),
        .rw_wr_stb   (rw_wr_stb),
        .ro_regs     (ro_regs),
        .ro_rd_clr   (ro_rd_clr)
    );

    always #5 clk = ~clk;

    // RO reg 0 behaves like a hardware counter that clears on the COR pulse
    always @(posedge clk) ro0 <= rst ? 32'd7 : ro_rd_clr[0] ? 32'd0 : ro0;
    assign ro_regs = {32'h0000_0000, 32'hCAFE_BABE, 32'h1234_5678, ro0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.IP2Bus_RdAck || bus.IP2Bus_WrAck) begin
            acks++;
            if (q.size() == 0) chk("unexpected_ack_queue_size", 64'(q.size()), 64'd1);
            else begin
                cur = q.pop_front();
                chk("rdack", 64'(bus.IP2Bus_RdAck), 64'(cur.rnw));
                chk("wrack", 64'(bus.IP2Bus_WrAck), 64'(!cur.rnw));
                chk("error", 64'(bus.IP2Bus_Error), 64'(cur.err));
                if (cur.rnw) chk("rdata", 64'(bus.IP2Bus_Data), 64'(cur.data));
                chk("wo_wr_stb", 64'(wo_wr_stb), 64'(cur.wo_stb));
                chk("rw_wr_stb", 64'(rw_wr_stb), 64'(cur.rw_stb));
                chk("ro_rd_clr", 64'(ro_rd_clr), 64'(cur.clr));
                chk("wo_regs", wo_regs, cur.wo);
                chk("rw_regs", rw_regs, cur.rw);
            end
        end else chk("idle_err_stb", 64'({bus.IP2Bus_Error, wo_wr_stb, rw_wr_stb, ro_rd_clr}), 64'd0);
    end

    task automatic xfer(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold, input logic err, input logic [31:0] rdata,
                        input logic [1:0] wo_stb, input logic [1:0] rw_stb, input logic [3:0] clr,
                        input logic [63:0] wo, input logic [63:0] rw);
        exp_t e;
        e.rnw = rnw; e.err = err; e.data = rdata; e.wo_stb = wo_stb;
        e.rw_stb = rw_stb; e.clr = clr; e.wo = wo; e.rw = rw;
        q.push_back(e);
        pushes++;
        @(negedge clk);
        bus.Bus2IP_Addr = addr;
        bus.Bus2IP_RNW  = rnw;
        bus.Bus2IP_Data = wdata;
        bus.Bus2IP_BE   = be;
        bus.Bus2IP_CS   = 1'b1;
        @(negedge clk);
        chk("ack_latency", 64'(bus.IP2Bus_RdAck || bus.IP2Bus_WrAck), 64'd1);
        if (hold >= 0) begin
            repeat (hold) @(negedge clk);
            bus.Bus2IP_CS = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        bus.Bus2IP_CS   = 1'b0;
        bus.Bus2IP_RNW  = 1'b1;
        bus.Bus2IP_Addr = '0;
        bus.Bus2IP_Data = '0;
        bus.Bus2IP_BE   = '0;
        repeat (3) @(negedge clk);
        chk("rst_data", 64'(bus.IP2Bus_Data), 64'd0);
        chk("rst_acks", 64'({bus.IP2Bus_RdAck, bus.IP2Bus_WrAck}), 64'd0);
        chk("rst_wo", wo_regs, 64'd0);
        chk("rst_rw", rw_regs, RW_RST);
        rst = 1'b0;
        //   rnw addr   wdata          be    hold err rdata          wo_stb rw_stb clr      wo                       rw
        xfer(1, 'h08, 32'h0,         4'h0, 0, 0, 32'hA5A5_A5A5, 2'b00, 2'b00, 4'b0000, 64'h0,                   RW_RST);
        xfer(1, 'h0C, 32'h0,         4'h0, 0, 0, 32'h0BAD_F00D, 2'b00, 2'b00, 4'b0000, 64'h0,                   RW_RST);
        xfer(0, 'h00, 32'h1122_3344, 4'hF, 0, 0, 32'h0,         2'b01, 2'b00, 4'b0000, 64'h0000_0000_1122_3344, RW_RST);
        xfer(0, 'h00, 32'hFFFF_FFFF, 4'h2, 0, 0, 32'h0,         2'b01, 2'b00, 4'b0000, 64'h0000_0000_1122_FF44, RW_RST);
        xfer(0, 'h04, 32'hDEAD_BEEF, 4'hF, 5, 0, 32'h0,         2'b10, 2'b00, 4'b0000, WOF,                     RW_RST);
        xfer(0, 'h08, 32'h5566_7788, 4'hC, 0, 0, 32'h0,         2'b00, 2'b01, 4'b0000, WOF,                     RW6);
        xfer(0, 'h0C, 32'hFFFF_FFFF, 4'h0, 0, 0, 32'h0,         2'b00, 2'b10, 4'b0000, WOF,                     RW6);
        xfer(1, 'h08, 32'h0,         4'h0, 0, 0, 32'h5566_A5A5, 2'b00, 2'b00, 4'b0000, WOF,                     RW6);
        xfer(1, 'h10, 32'h0,         4'h0, 0, 0, 32'h0000_0007, 2'b00, 2'b00, 4'b0001, WOF,                     RW6);
        xfer(1, 'h10, 32'h0,         4'h0, 0, 0, 32'h0000_0000, 2'b00, 2'b00, 4'b0001, WOF,                     RW6);
        xfer(1, 'h14, 32'h0,         4'h0, 0, 0, 32'h1234_5678, 2'b00, 2'b00, 4'b0000, WOF,                     RW6);
        xfer(1, 'h18, 32'h0,         4'h0, 0, 0, 32'hCAFE_BABE, 2'b00, 2'b00, 4'b0000, WOF,                     RW6);
        xfer(1, 'h1C, 32'h0,         4'h0, 0, 0, 32'h0000_0000, 2'b00, 2'b00, 4'b0000, WOF,                     RW6);
        xfer(0, 'h10, 32'hFFFF_FFFF, 4'hF, 0, 1, 32'h0,         2'b00, 2'b00, 4'b0000, WOF,                     RW6);
        xfer(1, 'h00, 32'h0,         4'h0, 0, 1, 32'h0000_0000, 2'b00, 2'b00, 4'b0000, WOF,                     RW6);
        xfer(1, 'h14, 32'h0,         4'h0, 0, 0, 32'h1234_5678, 2'b00, 2'b00, 4'b0000, WOF,                     RW6);
        xfer(1, 'h40, 32'h0,         4'h0, 0, 1, 32'h0000_0000, 2'b00, 2'b00, 4'b0000, WOF,                     RW6);
        xfer(0, 'h40, 32'hFFFF_FFFF, 4'hF, 0, 1, 32'h0,         2'b00, 2'b00, 4'b0000, WOF,                     RW6);
        xfer(1, 'h20, 32'h0,         4'h0, 0, 1, 32'h0000_0000, 2'b00, 2'b00, 4'b0000, WOF,                     RW6);
        xfer(1, 'h18, 32'h0,         4'h0, 0, 0, 32'hCAFE_BABE, 2'b00, 2'b00, 4'b0000, WOF,                     RW6);
        // write lands, then reset arrives while the bus still holds CS in HOLD
        xfer(0, 'h08, 32'h0,         4'hF, -1, 0, 32'h0,        2'b00, 2'b01, 4'b0000, WOF,                     64'h0BAD_F00D_0000_0000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_data", 64'(bus.IP2Bus_Data), 64'd0);
        chk("midrst_acks", 64'({bus.IP2Bus_RdAck, bus.IP2Bus_WrAck}), 64'd0);
        chk("midrst_wo", wo_regs, 64'd0);
        chk("midrst_rw", rw_regs, RW_RST);
        rst = 1'b0;
        bus.Bus2IP_CS = 1'b0;
        repeat (2) @(negedge clk);
        xfer(1, 'h08, 32'h0,         4'h0, 0, 0, 32'hA5A5_A5A5, 2'b00, 2'b00, 4'b0000, 64'h0,                   RW_RST);
        xfer(1, 'h10, 32'h0,         4'h0, 0, 0, 32'h0000_0007, 2'b00, 2'b00, 4'b0001, 64'h0,                   RW_RST);
        repeat (4) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);
        chk("ack_count", 64'(acks), 64'(pushes));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
